time_entry: RTL and testbench

- Operator-side time-entry block for the microwave controller; produces the min/sec preset that the countdown timer loads while idle.
- Converts three raw push-buttons (minute increment, second increment, clear) into saturating-free, wrap-around min/sec registers.
- Per-button synchronizing, debouncing and auto-repeat on hold.
- Locks the values while the timer is running.

---
 rtl/time_entry_pkg.sv | 14 +
 rtl/time_entry_if.sv | 26 ++
 rtl/time_entry_button_conditioner.sv | 114 +++++++++++
 rtl/time_entry.sv | 80 ++++++++
 tb/tb_time_entry.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/time_entry_pkg.sv
// Shared constants and conditioner state encoding for the microwave time-entry block.
package time_entry_pkg;

  localparam int         CNT_W   = 32;
  localparam logic [6:0] MAX_MIN = 7'd99;
  localparam logic [6:0] MAX_SEC = 7'd59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } cond_state_t;

endpackage

// File: rtl/time_entry_if.sv
// Button, lock and preset signals of the time-entry block, plus per-button conditioner state for observation.
interface time_entry_if;
  import time_entry_pkg::*;

  logic        btn_min;
  logic        btn_sec;
  logic        btn_clr;
  logic        busy;
  logic [6:0]  min;
  logic [6:0]  sec;
  logic        changed;
  cond_state_t min_state;
  cond_state_t sec_state;
  cond_state_t clr_state;

  modport master (
    output btn_min, btn_sec, btn_clr, busy,
    input  min, sec, changed, min_state, sec_state, clr_state
  );

  modport slave (
    input  btn_min, btn_sec, btn_clr, busy,
    output min, sec, changed, min_state, sec_state, clr_state
  );

endinterface

// File: rtl/time_entry_button_conditioner.sv
// One push-button: 2-FF synchronizer, debounce to an accepted level, and press/hold/auto-repeat step generation.
module button_conditioner
  import time_entry_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 500000,
  parameter int HOLD_COUNT     = 25000000,
  parameter int REPEAT_COUNT   = 10000000,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn,
  output logic        step,
  output cond_state_t state
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_COUNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_COUNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_COUNT - 1);

  logic             sync1, sync2;
  logic [1:0]       fill;
  logic             armed;
  logic             level;
  logic             acc_rise, acc_fall;
  logic [CNT_W-1:0] db_cnt;
  cond_state_t      state_n;
  logic [CNT_W-1:0] timer, timer_n;

  // armed stays low until a genuinely sampled release is seen, so a button
  // held through reset never produces a step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      fill     <= 2'b00;
      armed    <= 1'b0;
      level    <= 1'b0;
      acc_rise <= 1'b0;
      acc_fall <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      fill     <= {fill[0], 1'b1};
      acc_rise <= 1'b0;
      acc_fall <= 1'b0;
      if (fill[1] && !sync2) armed <= 1'b1;
      if (sync2 != level) begin
        if (db_cnt == DB_LAST) begin
          level    <= sync2;
          db_cnt   <= '0;
          acc_rise <= sync2;
          acc_fall <= ~sync2;
        end else begin
          db_cnt <= db_cnt + CNT_ONE;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
    end
  end

  // A release always wins over a repeat step due in the same cycle.
  always_comb begin
    state_n = state;
    timer_n = timer + CNT_ONE;
    step    = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (acc_rise && armed) begin
          step    = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (acc_fall) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (timer == HOLD_LAST) begin
          step    = REPEAT_EN;
          state_n = REPEAT;
          timer_n = '0;
        end
      end
      REPEAT: begin
        if (acc_fall) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (timer == REP_LAST) begin
          step    = REPEAT_EN;
          timer_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

endmodule

// File: rtl/time_entry.sv
// Microwave time entry: three conditioned buttons drive wrap-around min/sec preset registers, locked while busy.
module time_entry
  import time_entry_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 500000,
  parameter int HOLD_COUNT     = 25000000,
  parameter int REPEAT_COUNT   = 10000000
) (
  input  logic         clock,
  input  logic         reset,
  time_entry_if.slave  bus
);

  logic       min_step, sec_step, clr_step;
  logic [6:0] min_q, sec_q;
  logic       changed_q;
  logic       sec_wrap;
  logic [6:0] sec_next;
  logic [7:0] min_sum;
  logic [6:0] min_next;
  logic       apply;

  button_conditioner #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT), .HOLD_COUNT(HOLD_COUNT),
    .REPEAT_COUNT(REPEAT_COUNT), .REPEAT_EN(1'b1)
  ) u_min (
    .clock(clock), .reset(reset), .btn(bus.btn_min),
    .step(min_step), .state(bus.min_state)
  );

  button_conditioner #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT), .HOLD_COUNT(HOLD_COUNT),
    .REPEAT_COUNT(REPEAT_COUNT), .REPEAT_EN(1'b1)
  ) u_sec (
    .clock(clock), .reset(reset), .btn(bus.btn_sec),
    .step(sec_step), .state(bus.sec_state)
  );

  button_conditioner #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT), .HOLD_COUNT(HOLD_COUNT),
    .REPEAT_COUNT(REPEAT_COUNT), .REPEAT_EN(1'b0)
  ) u_clr (
    .clock(clock), .reset(reset), .btn(bus.btn_clr),
    .step(clr_step), .state(bus.clr_state)
  );

  // Minutes can advance by two when a min step meets a seconds carry.
  always_comb begin
    sec_wrap = sec_step && (sec_q == MAX_SEC);
    sec_next = sec_q;
    if (sec_step) sec_next = sec_wrap ? 7'd0 : sec_q + 7'd1;
    min_sum  = {1'b0, min_q} + {7'd0, min_step} + {7'd0, sec_wrap};
    min_next = (min_sum > {1'b0, MAX_MIN}) ? 7'(min_sum - 8'd100) : min_sum[6:0];
    apply    = !bus.busy && (min_step || sec_step || clr_step);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      min_q     <= 7'd0;
      sec_q     <= 7'd0;
      changed_q <= 1'b0;
    end else begin
      changed_q <= apply;
      if (apply) begin
        if (clr_step) begin
          min_q <= 7'd0;
          sec_q <= 7'd0;
        end else begin
          min_q <= min_next;
          sec_q <= sec_next;
        end
      end
    end
  end

  assign bus.min     = min_q;
  assign bus.sec     = sec_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_time_entry.sv
// Bench for time_entry: directed scenarios and random button activity against a schedule-based preset model.
module tb_time_entry;
  import time_entry_pkg::*;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 5;
  localparam int HIST = 8192;

  logic clock = 1'b0;
  logic reset = 1'b0;

  time_entry_if bus ();

  time_entry #(
    .DEBOUNCE_COUNT(D), .HOLD_COUNT(H), .REPEAT_COUNT(R)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int chg_seen = 0;

  bit raw_h [3][HIST];
  bit busy_h[HIST];
  bit m_acc  [3];
  bit m_hold [3];
  bit m_armed[3];
  int m_a    [3];
  int exp_val;
  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Accepted level flips once the raw level has been steady for D cycles
  // (seen through the 2-cycle synchronizer); steps follow a press at
  // offsets 0, H, H+R, H+2R ... until the release is accepted.
  function automatic bit raw_at(input int b, input int k);
    return (k < 0) ? 1'b0 : raw_h[b][k];
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int b = 0; b < 3; b++) begin
      m_acc[b]   = 1'b0;
      m_hold[b]  = 1'b0;
      m_armed[b] = 1'b0;
      m_a[b]     = 0;
    end
    exp_val = 0;
    exp_q.delete();
  endtask

  task automatic model_cycle(input int t);
    bit st[3];
    bit rise, fall, hi, lo, chg;
    int d;
    for (int b = 0; b < 3; b++) begin
      st[b] = 1'b0;
      rise  = 1'b0;
      fall  = 1'b0;
      if (t >= 3 && raw_h[b][t-3] == 1'b0) m_armed[b] = 1'b1;
      hi = 1'b1;
      lo = 1'b1;
      for (int k = t - D - 2; k <= t - 3; k++) begin
        if (raw_at(b, k)) lo = 1'b0;
        else hi = 1'b0;
      end
      if (!m_acc[b] && hi) begin
        rise = 1'b1;
        m_acc[b] = 1'b1;
      end else if (m_acc[b] && lo) begin
        fall = 1'b1;
        m_acc[b] = 1'b0;
      end
      if (rise && m_armed[b]) begin
        st[b]     = 1'b1;
        m_hold[b] = 1'b1;
        m_a[b]    = t;
      end else if (fall) begin
        m_hold[b] = 1'b0;
      end else if (m_hold[b] && b != 2 && t > m_a[b]) begin
        d = t - m_a[b];
        if (d == H || (d > H && (d - H) % R == 0)) st[b] = 1'b1;
      end
    end
    chg = !busy_h[t] && (st[0] || st[1] || st[2]);
    if (chg) begin
      if (st[2]) exp_val = 0;
      else exp_val = (exp_val + int'(st[1]) + 60 * int'(st[0])) % 6000;
    end
    exp_q.push_back({7'(exp_val / 60), 7'(exp_val % 60), chg});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [14:0] e;
    if (cyc >= HIST) begin
      $display("FAIL history_overflow: got cycle %0d, expected below %0d", cyc, HIST);
      $fatal(1);
    end
    raw_h[0][cyc] = bus.btn_min;
    raw_h[1][cyc] = bus.btn_sec;
    raw_h[2][cyc] = bus.btn_clr;
    busy_h[cyc]   = bus.busy;
    @(posedge clock);
    model_cycle(cyc);
    cyc++;
    @(negedge clock);
    e = exp_q.pop_front();
    check("cyc_min", 32'(bus.min), 32'(e[14:8]));
    check("cyc_sec", 32'(bus.sec), 32'(e[7:1]));
    check("cyc_changed", 32'(bus.changed), 32'(e[0]));
    if (bus.changed) chg_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [2:0] mask, input int hold, input int gap);
    bus.btn_min = mask[0];
    bus.btn_sec = mask[1];
    bus.btn_clr = mask[2];
    ticks(hold);
    bus.btn_min = 1'b0;
    bus.btn_sec = 1'b0;
    bus.btn_clr = 1'b0;
    ticks(gap);
  endtask

  task automatic check_val(input string tag, input int m, input int s);
    check({tag, "_min"}, 32'(bus.min), m);
    check({tag, "_sec"}, 32'(bus.sec), s);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected end within time budget");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.btn_min = 1'b0;
    bus.btn_sec = 1'b0;
    bus.btn_clr = 1'b0;
    bus.busy    = 1'b0;
    reset       = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_min", 32'(bus.min), 0);
    check("rst_sec", 32'(bus.sec), 0);
    check("rst_changed", 32'(bus.changed), 0);
    reset = 1'b1;
    model_reset();
    ticks(5);

    // clear at 0:00 still pulses changed
    chg_seen = 0;
    press(3'b100, 8, 12);
    check("clr_zero_pulses", chg_seen, 1);
    check_val("clr_zero", 0, 0);

    // single press: value moves exactly 7 cycles after the raw edge
    chg_seen = 0;
    bus.btn_sec = 1'b1;
    ticks(6);
    check("single_cycle6_sec", 32'(bus.sec), 0);
    ticks(1);
    check("single_cycle7_sec", 32'(bus.sec), 1);
    check("single_cycle7_changed", 32'(bus.changed), 1);
    ticks(3);
    bus.btn_sec = 1'b0;
    ticks(12);
    check("single_pulses", chg_seen, 1);

    // hold boundary: released right at the first repeat point vs one cycle later
    chg_seen = 0;
    press(3'b010, 20, 12);
    check("hold20_pulses", chg_seen, 1);
    chg_seen = 0;
    press(3'b010, 21, 12);
    check("hold21_pulses", chg_seen, 2);
    check_val("hold_boundary", 0, 4);

    // bounce: 2-cycle toggles are rejected, the settled press counts once
    chg_seen = 0;
    for (int i = 0; i < 15; i++) begin
      bus.btn_min = ~bus.btn_min;
      ticks(2);
    end
    check("bounce_quiet", chg_seen, 0);
    ticks(10);
    bus.btn_min = 1'b0;
    ticks(12);
    check("bounce_pulses", chg_seen, 1);
    check_val("bounce", 1, 4);

    // auto-repeat across the seconds wrap
    press(3'b100, 8, 12);
    press(3'b010, 296, 12);
    check_val("to_0_57", 0, 57);
    press(3'b010, 60, 12);
    check_val("auto_repeat", 1, 6);

    // carry collision at 99:59
    press(3'b100, 8, 12);
    press(3'b001, 506, 12);
    press(3'b010, 306, 12);
    check_val("to_99_59", 99, 59);
    chg_seen = 0;
    press(3'b011, 8, 12);
    check_val("carry_collision", 1, 0);
    check("carry_pulses", chg_seen, 1);

    // clear beats a simultaneous sec step
    press(3'b100, 8, 12);
    press(3'b001, 71, 12);
    press(3'b010, 181, 12);
    check_val("to_12_34", 12, 34);
    chg_seen = 0;
    press(3'b110, 8, 12);
    check_val("clr_priority", 0, 0);
    check("clr_priority_pulses", chg_seen, 1);

    // busy locks every button
    press(3'b010, 8, 12);
    bus.busy = 1'b1;
    chg_seen = 0;
    press(3'b001, 30, 10);
    press(3'b010, 30, 10);
    press(3'b100, 30, 10);
    check_val("busy_lock", 0, 1);
    check("busy_pulses", chg_seen, 0);
    bus.busy = 1'b0;
    ticks(5);

    // async reset in the middle of auto-repeat, button still held afterwards
    press(3'b100, 8, 12);
    press(3'b001, 36, 12);
    press(3'b010, 151, 12);
    check_val("to_5_28", 5, 28);
    bus.btn_sec = 1'b1;
    ticks(30);
    check_val("at_5_30", 5, 30);
    reset = 1'b0;
    #1;
    check("async_rst_min", 32'(bus.min), 0);
    check("async_rst_sec", 32'(bus.sec), 0);
    check("async_rst_changed", 32'(bus.changed), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    chg_seen = 0;
    ticks(40);
    check("held_through_reset_pulses", chg_seen, 0);
    bus.btn_sec = 1'b0;
    ticks(12);
    press(3'b010, 8, 12);
    check_val("after_rerelease", 0, 1);

    // random raw activity on all buttons and busy
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) bus.btn_min = ~bus.btn_min;
      if ($urandom_range(0, 9) == 0) bus.btn_sec = ~bus.btn_sec;
      if ($urandom_range(0, 29) == 0) bus.btn_clr = ~bus.btn_clr;
      if ($urandom_range(0, 49) == 0) bus.busy = ~bus.busy;
      tick();
    end
    bus.btn_min = 1'b0;
    bus.btn_sec = 1'b0;
    bus.btn_clr = 1'b0;
    bus.busy    = 1'b0;
    ticks(40);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
